// File: rtl/blc_bayer_pkg.sv
// Shared types and helpers for the Bayer black level calibration block.
//   cfa_ch_t    : CFA channel index (R, GR, GB, B), also the packed-level slot index
//   blc_state_t : statistics FSM states
//   ch_sel()    : channel of a pixel from its row/column parity and the R-site phase
package blc_bayer_pkg;

  typedef enum logic [1:0] {
    R  = 2'd0,
    GR = 2'd1,
    GB = 2'd2,
    B  = 2'd3
  } cfa_ch_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DIV,
    DONE
  } blc_state_t;

  function automatic cfa_ch_t ch_sel(input logic row_lsb, input logic col_lsb,
                                     input logic [1:0] phase);
    return cfa_ch_t'({row_lsb ^ phase[1], col_lsb ^ phase[0]});
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle used across the video pipeline.
//   master : drives tvalid/tdata/tstrb/tkeep/tlast/tuser/tid/tdest, samples tready
//   slave  : samples the payload, drives tready
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 16,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tstrb;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;
  logic [TUSER_WIDTH-1:0]     tuser;
  logic [TID_WIDTH-1:0]       tid;
  logic [TDEST_WIDTH-1:0]     tdest;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                  output tready);
endinterface

// File: rtl/blc_bayer_stat.sv
// Optically-black row statistics for blc_bayer.
//   beat_i/tuser_i/tlast_i/px_i : accepted input beat and its pixel
//   cfa_phase_i  : R-site parity (bit0 column, bit1 row)
//   ch_o         : CFA channel of the pixel currently on the input (combinational)
//   stat_bl_o    : last completed per-channel means, stat_valid_o pulses on update
//   stat_nxt_o   : value stat_bl_o holds after this edge (lets a coincident
//                  calibration strobe pick up the fresh means)
module blc_bayer_stat
  import blc_bayer_pkg::*;
#(
  parameter int unsigned PX_WIDTH         = 10,
  parameter int unsigned FRAME_RES_X      = 1920,
  parameter int unsigned FRAME_RES_Y      = 1080,
  parameter int unsigned OB_ROWS          = 8,
  parameter int unsigned INIT_BLACK_LEVEL = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  beat_i,
  input  logic                  tuser_i,
  input  logic                  tlast_i,
  input  logic [PX_WIDTH-1:0]   px_i,
  input  logic [1:0]            cfa_phase_i,
  output cfa_ch_t               ch_o,
  output logic [4*PX_WIDTH-1:0] stat_bl_o,
  output logic [4*PX_WIDTH-1:0] stat_nxt_o,
  output logic                  stat_valid_o
);
  localparam int unsigned N     = (OB_ROWS / 2) * (FRAME_RES_X / 2);
  localparam int unsigned ACC_W = PX_WIDTH + $clog2(N + 1);
  localparam int unsigned COL_W = $clog2(FRAME_RES_X + 1);
  localparam int unsigned ROW_W = $clog2(FRAME_RES_Y + 1);

  localparam logic [PX_WIDTH-1:0] INIT_BL = PX_WIDTH'(INIT_BLACK_LEVEL);
  localparam logic [ACC_W-1:0]    N_W     = ACC_W'(N);
  localparam logic [ACC_W-1:0]    HALF_N  = ACC_W'(N / 2);
  localparam logic [ACC_W:0]      PX_MAX  = (ACC_W + 1)'((1 << PX_WIDTH) - 1);
  localparam logic [ROW_W-1:0]    OB_END  = ROW_W'(OB_ROWS);
  localparam logic [ROW_W-1:0]    OB_LAST = ROW_W'(OB_ROWS - 1);

  logic [COL_W-1:0] col_q, col_eff;
  logic [ROW_W-1:0] row_q, row_eff;
  logic             in_ob;
  logic [ACC_W-1:0] px_ext;

  // A start-of-frame beat is itself pixel (0,0) regardless of the counters.
  always_comb begin
    col_eff = tuser_i ? '0 : col_q;
    row_eff = tuser_i ? '0 : row_q;
    in_ob   = (row_eff < OB_END);
    px_ext  = ACC_W'(px_i);
  end

  assign ch_o = ch_sel(row_eff[0], col_eff[0], cfa_phase_i);

  // Counters saturate so an overlong frame can never wrap back into the OB rows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (beat_i) begin
      if (tlast_i) begin
        col_q <= '0;
        row_q <= (&row_eff) ? row_eff : row_eff + 1'b1;
      end else begin
        col_q <= (&col_eff) ? col_eff : col_eff + 1'b1;
        row_q <= row_eff;
      end
    end
  end

  blc_state_t          state_q;
  logic [ACC_W-1:0]    sum_q [4];
  logic [PX_WIDTH-1:0] res_q [4];
  logic [1:0]          div_ch_q;
  logic                div_go_q;
  logic                div_valid;
  logic [ACC_W-1:0]    div_quo, div_rem;
  logic [ACC_W:0]      rnd;
  logic [PX_WIDTH-1:0] rounded;
  logic [4*PX_WIDTH-1:0] res_packed;

  division #(
    .WIDTH (ACC_W)
  ) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_go_q),
    .dividend_i  (sum_q[div_ch_q]),
    .divisor_i   (N_W),
    .valid_o     (div_valid),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    rnd     = {1'b0, div_quo} + (ACC_W + 1)'(div_rem >= HALF_N);
    rounded = (rnd > PX_MAX) ? '1 : rnd[PX_WIDTH-1:0];
  end

  always_comb begin
    res_packed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      res_packed[c*PX_WIDTH +: PX_WIDTH] = res_q[c];
    end
    stat_nxt_o = (state_q == DONE) ? res_packed : stat_bl_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      div_ch_q     <= '0;
      div_go_q     <= 1'b0;
      stat_valid_o <= 1'b0;
      stat_bl_o    <= {4{INIT_BL}};
      for (int unsigned c = 0; c < 4; c++) begin
        sum_q[c] <= '0;
        res_q[c] <= INIT_BL;
      end
    end else begin
      div_go_q     <= 1'b0;
      stat_valid_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (beat_i && tuser_i) begin
            for (int unsigned c = 0; c < 4; c++) begin
              sum_q[c] <= (2'(c) == ch_o) ? px_ext : '0;
            end
            state_q <= ACC;
          end
        end
        ACC: begin
          if (beat_i) begin
            if (tuser_i) begin
              for (int unsigned c = 0; c < 4; c++) begin
                sum_q[c] <= (2'(c) == ch_o) ? px_ext : '0;
              end
            end else begin
              if (in_ob) begin
                sum_q[ch_o] <= sum_q[ch_o] + px_ext;
              end
              if (tlast_i && (row_eff == OB_LAST)) begin
                state_q  <= DIV;
                div_ch_q <= '0;
                div_go_q <= 1'b1;
              end
            end
          end
        end
        DIV: begin
          // Sums are frozen here; a new frame start is deliberately ignored.
          if (div_valid) begin
            res_q[div_ch_q] <= rounded;
            if (div_ch_q == 2'd3) begin
              state_q <= DONE;
            end else begin
              div_ch_q <= div_ch_q + 1'b1;
              div_go_q <= 1'b1;
            end
          end
        end
        DONE: begin
          stat_bl_o    <= res_packed;
          stat_valid_o <= 1'b1;
          if (beat_i && tuser_i) begin
            for (int unsigned c = 0; c < 4; c++) begin
              sum_q[c] <= (2'(c) == ch_o) ? px_ext : '0;
            end
            state_q <= ACC;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/division.sv
// Sequential restoring unsigned divider, one quotient bit per cycle.
//   start_i     : load operands (ignored while a division is running)
//   dividend_i  : numerator, divisor_i : denominator
//   valid_o     : one-cycle pulse when quotient_o/remainder_o are final;
//                 results hold until the next start
module division #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    fits  = (trial >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (busy_q) begin
        // trial < 2*divisor, so the difference always fits back in WIDTH bits
        rem_q <= fits ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], fits};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q  <= 1'b0;
          valid_o <= 1'b1;
        end
      end else if (start_i) begin
        quo_q  <= dividend_i;
        rem_q  <= '0;
        dvs_q  <= divisor_i;
        cnt_q  <= CNT_W'(WIDTH);
        busy_q <= 1'b1;
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/blc_bayer.sv
// Per-CFA-phase black level subtraction for raw Bayer AXI4-Stream video.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   video_i       : raw input (tuser = start of frame, tlast = end of line)
//   video_o       : corrected output, one register stage, sidebands aligned
//   cfa_phase_i   : R-site parity (bit0 column, bit1 row)
//   mode_i        : 0 = auto (levels from OB statistics), 1 = manual
//   man_bl_i      : manual levels, channel c at [c*PX_WIDTH +: PX_WIDTH]
//   cal_stb_i     : copy latest statistics into the active levels (auto mode)
//   stat_bl_o     : latest OB means, stat_valid_o pulses when they change
//   cur_bl_o      : active levels used by the subtraction
module blc_bayer
  import blc_bayer_pkg::*;
#(
  parameter int unsigned PX_WIDTH         = 10,
  parameter int unsigned FRAME_RES_X      = 1920,
  parameter int unsigned FRAME_RES_Y      = 1080,
  parameter int unsigned OB_ROWS          = 8,
  parameter int unsigned INIT_BLACK_LEVEL = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi4_stream_if.slave          video_i,
  axi4_stream_if.master         video_o,
  input  logic [1:0]            cfa_phase_i,
  input  logic                  mode_i,
  input  logic [4*PX_WIDTH-1:0] man_bl_i,
  input  logic                  cal_stb_i,
  output logic [4*PX_WIDTH-1:0] stat_bl_o,
  output logic                  stat_valid_o,
  output logic [4*PX_WIDTH-1:0] cur_bl_o
);
  localparam int unsigned TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8;
  localparam logic [PX_WIDTH-1:0] INIT_BL = PX_WIDTH'(INIT_BLACK_LEVEL);

  logic                  en;
  logic                  beat;
  cfa_ch_t               ch;
  logic [PX_WIDTH-1:0]   px;
  logic [PX_WIDTH-1:0]   bl;
  logic [PX_WIDTH-1:0]   corr;
  logic [PX_WIDTH-1:0]   bl_arr [4];
  logic [4*PX_WIDTH-1:0] stat_nxt;

  assign en             = video_o.tready || !video_o.tvalid;
  assign video_i.tready = en;
  assign beat           = video_i.tvalid && en;
  assign px             = video_i.tdata[PX_WIDTH-1:0];

  if (TDATA_WIDTH > PX_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^video_i.tdata[TDATA_WIDTH-1:PX_WIDTH];
  end

  blc_bayer_stat #(
    .PX_WIDTH         (PX_WIDTH),
    .FRAME_RES_X      (FRAME_RES_X),
    .FRAME_RES_Y      (FRAME_RES_Y),
    .OB_ROWS          (OB_ROWS),
    .INIT_BLACK_LEVEL (INIT_BLACK_LEVEL)
  ) u_stat (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .beat_i       (beat),
    .tuser_i      (video_i.tuser[0]),
    .tlast_i      (video_i.tlast),
    .px_i         (px),
    .cfa_phase_i  (cfa_phase_i),
    .ch_o         (ch),
    .stat_bl_o    (stat_bl_o),
    .stat_nxt_o   (stat_nxt),
    .stat_valid_o (stat_valid_o)
  );

  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      bl_arr[c] = cur_bl_o[c*PX_WIDTH +: PX_WIDTH];
    end
    bl   = bl_arr[ch];
    corr = (px < bl) ? '0 : px - bl;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_bl_o <= {4{INIT_BL}};
    end else if (mode_i) begin
      cur_bl_o <= man_bl_i;
    end else if (cal_stb_i) begin
      cur_bl_o <= stat_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      video_o.tvalid <= 1'b0;
      video_o.tdata  <= '0;
      video_o.tstrb  <= '0;
      video_o.tkeep  <= '0;
      video_o.tlast  <= 1'b0;
      video_o.tuser  <= '0;
      video_o.tid    <= '0;
      video_o.tdest  <= '0;
    end else if (en) begin
      video_o.tvalid <= video_i.tvalid;
      video_o.tdata  <= TDATA_WIDTH'(corr);
      video_o.tstrb  <= video_i.tstrb;
      video_o.tkeep  <= video_i.tkeep;
      video_o.tlast  <= video_i.tlast;
      video_o.tuser  <= video_i.tuser;
      video_o.tid    <= video_i.tid;
      video_o.tdest  <= video_i.tdest;
    end
  end

endmodule

// File: tb/tb_blc_bayer.sv
// Self-checking bench for blc_bayer on a tiny 8x4 frame with two OB rows.
`timescale 1ns/1ps
module tb_blc_bayer;
  localparam int PXW  = 10;
  localparam int RX   = 8;
  localparam int RY   = 4;
  localparam int OBR  = 2;
  localparam int INIT = 16;
  localparam int TW   = 16;
  localparam int NS   = (OBR / 2) * (RX / 2);
  localparam int PMAX = (1 << PXW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(TW)) vin ();
  axi4_stream_if #(.TDATA_WIDTH(TW)) vout ();

  logic [1:0]       phase;
  logic             mode;
  logic [4*PXW-1:0] man_bl;
  logic             cal_stb;
  logic [4*PXW-1:0] stat_bl;
  logic             stat_valid;
  logic [4*PXW-1:0] cur_bl;

  blc_bayer #(
    .PX_WIDTH         (PXW),
    .FRAME_RES_X      (RX),
    .FRAME_RES_Y      (RY),
    .OB_ROWS          (OBR),
    .INIT_BLACK_LEVEL (INIT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .video_i      (vin),
    .video_o      (vout),
    .cfa_phase_i  (phase),
    .mode_i       (mode),
    .man_bl_i     (man_bl),
    .cal_stb_i    (cal_stb),
    .stat_bl_o    (stat_bl),
    .stat_valid_o (stat_valid),
    .cur_bl_o     (cur_bl)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int data; bit last; bit user; } beat_t;
  beat_t exp_q[$];

  int frame_px [RY][RX];
  int model_bl [4];
  int model_stat [4];
  int exp_stat [4];

  function automatic int chan(input int r, input int c);
    int ph;
    ph = int'(phase);
    return (((r ^ (ph >> 1)) & 1) * 2) + ((c ^ ph) & 1);
  endfunction

  function automatic void calc_stats();
    int s [4];
    int q, m, v;
    s = '{default: 0};
    for (int r = 0; r < OBR; r++)
      for (int c = 0; c < RX; c++)
        s[chan(r, c)] += frame_px[r][c];
    for (int k = 0; k < 4; k++) begin
      q = s[k] / NS;
      m = s[k] % NS;
      v = q + ((m >= NS / 2) ? 1 : 0);
      if (v > PMAX) v = PMAX;
      exp_stat[k] = v;
    end
  endfunction

  function automatic logic [4*PXW-1:0] pack(input int v [4]);
    logic [4*PXW-1:0] p;
    for (int k = 0; k < 4; k++) p[k*PXW +: PXW] = PXW'(v[k]);
    return p;
  endfunction

  // ---------------- clocking helpers / monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int rdy_pct = 100;
  int vld_pct = 100;
  int stat_cnt = 0;
  int in_sof_cyc = 0;
  int out_sof_cyc = 0;

  initial begin
    vout.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vout.tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (vout.tvalid && vout.tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("tdata", vout.tdata, b.data);
          check("tlast", vout.tlast, b.last);
          check("tuser", vout.tuser, b.user);
          if (b.user) out_sof_cyc = cyc;
        end
      end
      if (stat_valid) stat_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int r, input int c, input int px, input bit user, input bit last);
    beat_t e;
    int d;
    vin.tdata = TW'(px);
    vin.tuser = user;
    vin.tlast = last;
    while ($urandom_range(0, 99) >= vld_pct) begin
      vin.tvalid = 1'b0;
      tick(1);
    end
    vin.tvalid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (vin.tready) break;
      if (t > 1000) begin
        check("accept_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "input never accepted");
      end
      @(posedge clk);
      #1;
    end
    if (user) in_sof_cyc = cyc;
    d = px - model_bl[chan(r, c)];
    e.data = (d < 0) ? 0 : d;
    e.last = last;
    e.user = user;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    vin.tvalid = 1'b0;
  endtask

  int frame_start = 0;

  // nrows lines, the last one truncated to ncols_last; optional calibration
  // strobe in a gap right after the last OB line (statistics divider busy).
  task automatic send_frame(input int nrows, input int ncols_last, input bit cal_gap);
    int ncols;
    for (int r = 0; r < nrows; r++) begin
      ncols = (r == nrows - 1) ? ncols_last : RX;
      for (int c = 0; c < ncols; c++)
        send_beat(r, c, frame_px[r][c], (r == 0 && c == 0), (c == RX - 1));
      if (cal_gap && r == OBR - 1) begin
        tick(3);
        check("cal_div_busy", stat_cnt - frame_start, 0);
        cal_stb = 1'b1;
        tick(1);
        cal_stb = 1'b0;
        model_bl = model_stat;
        @(negedge clk);
        check("cal_in_div", cur_bl, pack(model_stat));
        tick(1);
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) tick(1);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_stats(input bit expect_new);
    for (int t = 0; t < 400 && stat_cnt == frame_start; t++) tick(1);
    tick(150);
    check("stat_count", stat_cnt - frame_start, expect_new ? 1 : 0);
    if (expect_new) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("stat_ch%0d", k), stat_bl[k*PXW +: PXW], exp_stat[k]);
      model_stat = exp_stat;
    end
  endtask

  task automatic run_frame(input bit cal_gap);
    calc_stats();
    frame_start = stat_cnt;
    send_frame(RY, RX, cal_gap);
    drain();
    wait_stats(1'b1);
  endtask

  task automatic pulse_cal();
    cal_stb = 1'b1;
    tick(1);
    cal_stb = 1'b0;
    model_bl = model_stat;
    @(negedge clk);
    check("cal_cur_bl", cur_bl, pack(model_stat));
    tick(1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < RY; r++)
      for (int c = 0; c < RX; c++)
        frame_px[r][c] = $urandom_range(0, PMAX);
  endtask

  int pat [4];
  int v200 [4];
  int v100 [4];

  initial begin
    rst = 1'b1;
    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tuser  = '0;
    vin.tlast  = 1'b0;
    vin.tstrb  = '1;
    vin.tkeep  = '1;
    vin.tid    = '0;
    vin.tdest  = '0;
    phase   = 2'd0;
    mode    = 1'b0;
    man_bl  = '0;
    cal_stb = 1'b0;
    model_bl   = '{default: INIT};
    model_stat = '{default: INIT};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cur_bl", cur_bl, {4{10'd16}});
    check("rst_stat_bl", stat_bl, {4{10'd16}});
    check("rst_stat_valid", stat_valid, 0);
    check("rst_tvalid", vout.tvalid, 0);
    check("rst_tdata", vout.tdata, 0);
    rst = 1'b0;
    tick(2);

    // flat field, full throughput
    for (int r = 0; r < RY; r++)
      for (int c = 0; c < RX; c++)
        frame_px[r][c] = 64;
    run_frame(1'b0);
    check("latency", out_sof_cyc - in_sof_cyc, 1);
    pulse_cal();
    check("flat_cur_bl", cur_bl, {4{10'd64}});
    run_frame(1'b0);

    // per-phase levels, random backpressure and valid gaps
    rdy_pct = 30;
    vld_pct = 70;
    pat = '{10, 20, 30, 40};
    fill_random();
    for (int r = 0; r < OBR; r++)
      for (int c = 0; c < RX; c++)
        frame_px[r][c] = pat[(r % 2) * 2 + (c % 2)];
    phase = 2'd0;
    run_frame(1'b0);
    check("phase0_levels", stat_bl, {10'd40, 10'd30, 10'd20, 10'd10});
    phase = 2'd3;
    fill_random();
    for (int r = 0; r < OBR; r++)
      for (int c = 0; c < RX; c++)
        frame_px[r][c] = pat[(r % 2) * 2 + (c % 2)];
    run_frame(1'b0);
    check("phase3_levels", stat_bl, {10'd10, 10'd20, 10'd30, 10'd40});
    phase = 2'd0;

    // rounding of the R mean (R sites: row 0, even columns)
    fill_random();
    frame_px[0][0] = 10; frame_px[0][2] = 11; frame_px[0][4] = 11; frame_px[0][6] = 10;
    run_frame(1'b0);
    check("round_up", stat_bl[PXW-1:0], 11);
    fill_random();
    frame_px[0][0] = 10; frame_px[0][2] = 10; frame_px[0][4] = 10; frame_px[0][6] = 11;
    run_frame(1'b0);
    check("round_down", stat_bl[PXW-1:0], 10);

    // calibration strobe while the divider is busy takes the previous means
    v200 = '{default: 200};
    mode = 1'b1;
    man_bl = pack(v200);
    tick(2);
    mode = 1'b0;
    model_bl = v200;
    tick(2);
    check("auto_hold", cur_bl, pack(v200));
    fill_random();
    run_frame(1'b1);

    // early frame start during OB row 1: only the following frame yields stats
    fill_random();
    calc_stats();
    frame_start = stat_cnt;
    send_frame(2, 3, 1'b0);
    fill_random();
    calc_stats();
    send_frame(RY, RX, 1'b0);
    drain();
    wait_stats(1'b1);

    // manual mode: clamp at zero, and saturated OB statistics
    v100 = '{default: 100};
    mode = 1'b1;
    man_bl = pack(v100);
    tick(2);
    model_bl = v100;
    check("manual_cur_bl", cur_bl, pack(v100));
    fill_random();
    for (int r = 0; r < OBR; r++)
      for (int c = 0; c < RX; c++)
        frame_px[r][c] = PMAX;
    frame_px[2][0] = 99;
    frame_px[2][1] = 100;
    frame_px[2][2] = PMAX;
    frame_px[2][3] = 101;
    run_frame(1'b0);
    check("sat_levels", stat_bl, {4{10'd1023}});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
